// File: rtl/argon_alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : argon_alu_seq_if
// Description : Command/response bundle for the argon_alu_seq sequential ALU.
//               master drives command, valid and write data; slave returns
//               read data, read-valid, busy and done.
//   i_Command [3:0]      command code (NOP/LATCHx/COMPUTE/OUTPUTx)
//   i_Valid              qualifies i_Command and i_Data
//   i_Data    [WIDTH-1:0] write data for LATCH commands
//   o_Data    [WIDTH-1:0] read data, zero when o_Valid is low
//   o_Valid              read data valid (combinational)
//   o_Busy               multi-cycle operation in progress (registered)
//   o_Done               one-cycle completion pulse (registered)
// Revision    : 1.0 - initial release
// ============================================================================
interface argon_alu_seq_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       i_Command;
    logic             i_Valid;
    logic [WIDTH-1:0] i_Data;
    logic [WIDTH-1:0] o_Data;
    logic             o_Valid;
    logic             o_Busy;
    logic             o_Done;

    modport master (
        output i_Command, i_Valid, i_Data,
        input  o_Data, o_Valid, o_Busy, o_Done
    );

    modport slave (
        input  i_Command, i_Valid, i_Data,
        output o_Data, o_Valid, o_Busy, o_Done
    );
endinterface
`default_nettype wire

// File: rtl/argon_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : argon_alu_seq
// Description : Command-driven sequential ALU. Operands, flags and opcode are
//               loaded with LATCH commands, COMPUTE evaluates rOp on rA/rB
//               into rY/rF, OUTPUTY/OUTPUTF read results back.
//               Optional shift-add multiplier enabled by macro
//               ARGON_ALU_MUL_EN; without it opcode 12 is illegal and
//               o_Busy is constant 0.
// Ports       : i_Clk   - clock, all state on rising edge
//               i_Reset - synchronous active-high reset
//               bus     - argon_alu_seq_if slave (command/data/status)
// Revision    : 1.0 - initial release
// ============================================================================
module argon_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic           i_Clk,
    input  logic           i_Reset,
    argon_alu_seq_if.slave bus
);
    localparam int c_SH_W = $clog2(WIDTH);

    localparam logic [3:0] c_CMD_LATCHA  = 4'd1;
    localparam logic [3:0] c_CMD_LATCHB  = 4'd2;
    localparam logic [3:0] c_CMD_LATCHF  = 4'd3;
    localparam logic [3:0] c_CMD_LATCHOP = 4'd4;
    localparam logic [3:0] c_CMD_COMPUTE = 4'd5;
    localparam logic [3:0] c_CMD_OUTY    = 4'd6;
    localparam logic [3:0] c_CMD_OUTF    = 4'd7;

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_ADC = 4'd1;
    localparam logic [3:0] c_OP_SUB = 4'd2;
    localparam logic [3:0] c_OP_SBC = 4'd3;
    localparam logic [3:0] c_OP_AND = 4'd4;
    localparam logic [3:0] c_OP_OR  = 4'd5;
    localparam logic [3:0] c_OP_XOR = 4'd6;
    localparam logic [3:0] c_OP_NOT = 4'd7;
    localparam logic [3:0] c_OP_SHL = 4'd8;
    localparam logic [3:0] c_OP_SHR = 4'd9;
    localparam logic [3:0] c_OP_ASR = 4'd10;
    localparam logic [3:0] c_OP_CMP = 4'd11;
    localparam logic [3:0] c_OP_MUL = 4'd12;

    logic [WIDTH-1:0] r_a, r_b, r_y, r_f;
    logic [3:0]       r_op;
    logic             r_done;

    logic             w_busy;
    logic             w_accept;
    logic             w_compute;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_y;
    logic [WIDTH-1:0] w_mul_f;

    // Nothing is accepted while the multiplier owns the datapath.
    assign w_accept  = bus.i_Valid && !w_busy;
    assign w_compute = w_accept && (bus.i_Command == c_CMD_COMPUTE);

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic             w_add_ci, w_sub_ci;
    logic [WIDTH:0]   w_sum, w_dif, w_sh;
    logic [c_SH_W-1:0] w_amt;
    logic [WIDTH-1:0] w_res, w_alu_f;
    logic             w_c, w_v, w_err, w_wr_y;

    always_comb begin
        w_add_ci = (r_op == c_OP_ADC) && r_f[0];
        w_sub_ci = (r_op == c_OP_SBC) && r_f[0];
        w_amt    = r_b[c_SH_W-1:0];
        w_sum    = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, w_add_ci};
        // Bit WIDTH of the extended difference is the unsigned borrow.
        w_dif    = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, w_sub_ci};
        w_sh     = '0;
        w_res    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_err    = 1'b0;
        w_wr_y   = 1'b1;
        case (r_op)
            c_OP_ADD, c_OP_ADC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_OP_SUB, c_OP_SBC, c_OP_CMP: begin
                w_res  = w_dif[WIDTH-1:0];
                w_c    = w_dif[WIDTH];
                w_v    = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                         (w_dif[WIDTH-1] != r_a[WIDTH-1]);
                w_wr_y = (r_op != c_OP_CMP);
            end
            c_OP_AND: w_res = r_a & r_b;
            c_OP_OR:  w_res = r_a | r_b;
            c_OP_XOR: w_res = r_a ^ r_b;
            c_OP_NOT: w_res = ~r_a;
            // Shifts run on a WIDTH+1 vector with a guard bit so the last
            // bit shifted out lands in the guard (and stays 0 for amount 0).
            c_OP_SHL: begin
                w_sh  = {1'b0, r_a} << w_amt;
                w_res = w_sh[WIDTH-1:0];
                w_c   = w_sh[WIDTH];
            end
            c_OP_SHR: begin
                w_sh  = {r_a, 1'b0} >> w_amt;
                w_res = w_sh[WIDTH:1];
                w_c   = w_sh[0];
            end
            c_OP_ASR: begin
                w_sh  = $signed({r_a, 1'b0}) >>> w_amt;
                w_res = w_sh[WIDTH:1];
                w_c   = w_sh[0];
            end
            default: w_err = 1'b1;
        endcase
        w_alu_f    = '0;
        w_alu_f[0] = w_c;
        w_alu_f[1] = (w_res == '0) && !w_err;
        w_alu_f[2] = w_res[WIDTH-1];
        w_alu_f[3] = w_v;
        w_alu_f[4] = w_err;
    end

    // ------------------------------------------------------------------
    // Optional shift-add multiplier
    // ------------------------------------------------------------------
`ifdef ARGON_ALU_MUL_EN
    localparam logic [0:0]        c_ST_IDLE  = 1'b0;
    localparam logic [0:0]        c_ST_BUSY  = 1'b1;
    localparam logic [c_SH_W-1:0] c_CNT_LAST = c_SH_W'(WIDTH - 1);

    logic [0:0]         r_state;
    logic               r_busy;
    logic [c_SH_W-1:0]  r_cnt;
    logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_next;
    logic [WIDTH-1:0]   r_mplier;

    assign w_is_mul   = (r_op == c_OP_MUL);
    assign w_busy     = r_busy;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    // The final partial product is folded in on the same edge that
    // writes rY/rF, so busy lasts exactly WIDTH cycles.
    assign w_mul_done = (r_state == c_ST_BUSY) && (r_cnt == c_CNT_LAST);
    assign w_mul_y    = w_acc_next[WIDTH-1:0];

    always_comb begin
        w_mul_f    = '0;
        w_mul_f[0] = |w_acc_next[2*WIDTH-1:WIDTH];
        w_mul_f[1] = (w_mul_y == '0);
        w_mul_f[2] = w_mul_y[WIDTH-1];
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state  <= c_ST_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_compute && w_is_mul) begin
                        r_state  <= c_ST_BUSY;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, r_a};
                        r_mplier <= r_b;
                        r_acc    <= '0;
                    end
                end
                default: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mul_done) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end
`else
    assign w_is_mul   = 1'b0;
    assign w_busy     = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_y    = '0;
    assign w_mul_f    = '0;
`endif

    // ------------------------------------------------------------------
    // Register file and command decode
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_y    <= '0;
            r_f    <= '0;
            r_op   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                case (bus.i_Command)
                    c_CMD_LATCHA:  r_a  <= bus.i_Data;
                    c_CMD_LATCHB:  r_b  <= bus.i_Data;
                    c_CMD_LATCHF:  r_f  <= bus.i_Data;
                    c_CMD_LATCHOP: r_op <= bus.i_Data[3:0];
                    c_CMD_COMPUTE: begin
                        if (!w_is_mul) begin
                            if (w_wr_y) begin
                                r_y <= w_res;
                            end
                            r_f    <= w_alu_f;
                            r_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_mul_done) begin
                r_y    <= w_mul_y;
                r_f    <= w_mul_f;
                r_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_Valid = w_accept &&
                         ((bus.i_Command == c_CMD_OUTY) || (bus.i_Command == c_CMD_OUTF));
    assign bus.o_Data  = !bus.o_Valid ? '0 :
                         (bus.i_Command == c_CMD_OUTY) ? r_y : r_f;
    assign bus.o_Busy  = w_busy;
    assign bus.o_Done  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_argon_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_argon_alu_seq
// Description : Self-checking bench for argon_alu_seq. Directed scenarios and
//               randomized command streams are compared against an
//               arithmetic reference model. Builds with or without
//               ARGON_ALU_MUL_EN. A second WIDTH=32 instance covers the
//               wide carry case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_argon_alu_seq;
`ifdef ARGON_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int W = 16;

    localparam logic [3:0] NOP = 4'd0, LA = 4'd1, LB = 4'd2, LF = 4'd3, LOP = 4'd4,
                           COMP = 4'd5, OUTY = 4'd6, OUTF = 4'd7;

    logic i_Clk = 1'b0;
    logic i_Reset = 1'b1;
    always #5 i_Clk = ~i_Clk;

    argon_alu_seq_if #(.WIDTH(W))  bus();
    argon_alu_seq_if #(.WIDTH(32)) bus32();

    argon_alu_seq #(.WIDTH(W))  dut   (.i_Clk(i_Clk), .i_Reset(i_Reset), .bus(bus));
    argon_alu_seq #(.WIDTH(32)) dut32 (.i_Clk(i_Clk), .i_Reset(i_Reset), .bus(bus32));

    int n_checks = 0;
    int n_pass   = 0;

    longint unsigned m_a, m_b, m_y, m_f, m_op;

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: plain integer arithmetic on w-bit values.
    function automatic void model(input int w, input longint unsigned op,
                                  input longint unsigned a, input longint unsigned b,
                                  input longint unsigned f,
                                  inout longint unsigned y, output longint unsigned fo);
        longint unsigned mask = (64'd1 << w) - 1;
        longint sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        longint sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        longint mx = (longint'(1) << (w-1)) - 1;
        longint mn = -(longint'(1) << (w-1));
        longint sr;
        longint unsigned res = 0, ci = 0, c = 0, v = 0, err = 0, p;
        int amt = int'(b % longint'(w));
        bit wr = 1;
        case (op)
            0, 1: begin
                ci = (op == 1) ? (f & 1) : 0;
                res = a + b + ci;
                c = (res >> w) & 1;
                sr = sa + sb + longint'(ci);
                v = (sr > mx || sr < mn) ? 1 : 0;
            end
            2, 3, 11: begin
                ci = (op == 3) ? (f & 1) : 0;
                c = (a < b + ci) ? 1 : 0;
                res = a - b - ci;
                sr = sa - sb - longint'(ci);
                v = (sr > mx || sr < mn) ? 1 : 0;
                wr = (op != 11);
            end
            4: res = a & b;
            5: res = a | b;
            6: res = a ^ b;
            7: res = ~a;
            8: begin res = a << amt; c = (amt == 0) ? 0 : (a >> (w - amt)) & 1; end
            9: begin res = a >> amt; c = (amt == 0) ? 0 : (a >> (amt - 1)) & 1; end
            10: begin res = longint'(sa >>> amt); c = (amt == 0) ? 0 : (a >> (amt - 1)) & 1; end
            12: begin
                if (MUL_EN) begin
                    p = a * b;
                    res = p;
                    c = ((p >> w) != 0) ? 1 : 0;
                end else err = 1;
            end
            default: err = 1;
        endcase
        res &= mask;
        if (err != 0) begin
            res = 0; c = 0; v = 0;
            fo = 64'h10;
        end else begin
            fo = c | ((res == 0) ? 64'd2 : 64'd0) | (((res >> (w-1)) & 1) << 2) | (v << 3);
        end
        if (wr) y = res;
    endfunction

    task automatic send(input logic [3:0] cmd, input logic [W-1:0] data);
        bus.i_Command = cmd;
        bus.i_Data    = data;
        bus.i_Valid   = 1'b1;
        @(posedge i_Clk); #1;
        bus.i_Valid   = 1'b0;
        bus.i_Command = NOP;
        bus.i_Data    = W'($urandom);
    endtask

    task automatic latch(input logic [3:0] cmd, input logic [W-1:0] data);
        send(cmd, data);
        case (cmd)
            LA: m_a = data;
            LB: m_b = data;
            LF: m_f = data;
            LOP: m_op = data & 4'hF;
            default: ;
        endcase
    endtask

    // Reads rY and rF combinationally; no clock edge is consumed.
    task automatic read_yf(output longint unsigned y, output longint unsigned f);
        bus.i_Valid = 1'b1;
        bus.i_Command = OUTY; #1;
        check("outy_valid", bus.o_Valid, 1);
        y = bus.o_Data;
        bus.i_Command = OUTF; #1;
        f = bus.o_Data;
        bus.i_Valid = 1'b0; #1;
        check("odata_idle", {bus.o_Valid, bus.o_Data}, 0);
        bus.i_Command = NOP;
    endtask

    task automatic compute(input string tag);
        longint unsigned y, f;
        int cyc = 0;
        bit mul = MUL_EN && (m_op == 12);
        send(COMP, W'($urandom));
        if (mul) begin
            check({tag, "_busy_rise"}, bus.o_Busy, 1);
            while (bus.o_Busy && cyc < 200) begin
                bus.i_Command = LA; bus.i_Data = W'($urandom); bus.i_Valid = 1'b1;
                @(posedge i_Clk); #1;
                bus.i_Valid = 1'b0;
                cyc++;
            end
            check({tag, "_busy_len"}, cyc, W);
        end
        model(W, m_op, m_a, m_b, m_f, m_y, m_f);
        check({tag, "_done"}, {bus.o_Busy, bus.o_Done}, 2'b01);
        read_yf(y, f);
        check({tag, "_y"}, y, m_y);
        check({tag, "_f"}, f, m_f);
        @(posedge i_Clk); #1;
        check({tag, "_done_fall"}, bus.o_Done, 0);
    endtask

    task automatic expect_yf(input string tag, input longint unsigned ey, input longint unsigned ef);
        longint unsigned y, f;
        read_yf(y, f);
        check({tag, "_y"}, y, ey);
        check({tag, "_f"}, f, ef);
    endtask

    task automatic send32(input logic [3:0] cmd, input logic [31:0] data);
        bus32.i_Command = cmd; bus32.i_Data = data; bus32.i_Valid = 1'b1;
        @(posedge i_Clk); #1;
        bus32.i_Valid = 1'b0; bus32.i_Command = NOP;
    endtask

    initial begin
        longint unsigned y0, f0, y1, f1;
        bus.i_Valid = 1'b0; bus.i_Command = NOP; bus.i_Data = '0;
        bus32.i_Valid = 1'b0; bus32.i_Command = NOP; bus32.i_Data = '0;
        m_a = 0; m_b = 0; m_y = 0; m_f = 0; m_op = 0;
        repeat (3) @(posedge i_Clk);
        #1 i_Reset = 1'b0;

        // Reset state
        check("rst_busy_done", {bus.o_Busy, bus.o_Done}, 0);
        expect_yf("rst", 0, 0);

        // ADD carry out to zero
        latch(LA, 16'hFFFF); latch(LB, 16'h0001); latch(LOP, 0);
        compute("add_c");
        expect_yf("add_c_k", 16'h0000, 16'h0003);

        // Signed overflow, then borrow
        latch(LA, 16'h7FFF);
        compute("add_v");
        expect_yf("add_v_k", 16'h8000, 16'h000C);
        latch(LA, 16'h0000); latch(LOP, 2);
        compute("sub_b");
        expect_yf("sub_b_k", 16'hFFFF, 16'h0005);

        // ASR and illegal opcode
        latch(LA, 16'h8001); latch(LB, 16'h0001); latch(LOP, 10);
        compute("asr");
        expect_yf("asr_k", 16'hC000, 16'h0005);
        latch(LOP, 14);
        compute("ill");
        expect_yf("ill_k", 0, 16'h0010);

        // Back-to-back ADC chaining carry through rF
        latch(LA, 16'hFFFF); latch(LB, 16'h0001); latch(LF, 0); latch(LOP, 1);
        bus.i_Command = COMP; bus.i_Valid = 1'b1;
        @(posedge i_Clk); #1;
        check("b2b_done1", bus.o_Done, 1);
        @(posedge i_Clk); #1;
        bus.i_Valid = 1'b0; bus.i_Command = NOP;
        check("b2b_done2", bus.o_Done, 1);
        model(W, m_op, m_a, m_b, m_f, m_y, m_f);
        model(W, m_op, m_a, m_b, m_f, m_y, m_f);
        read_yf(y1, f1);
        check("b2b_y", y1, 16'h0001);
        check("b2b_f", f1, 16'h0001);

        // Multiply (or illegal opcode 12)
        latch(LA, 16'h0100); latch(LB, 16'h0100); latch(LOP, 12);
        compute("mul");
        if (MUL_EN) expect_yf("mul_k", 0, 16'h0003);
        else        expect_yf("mul_k", 0, 16'h0010);
        // rA must have survived the LATCHA attempts made while busy
        latch(LB, 0); latch(LOP, 0);
        compute("mul_a_kept");
        expect_yf("mul_a_kept_k", 16'h0100, 0);

        // Reset in the 8th multiply cycle, colliding with a LATCHA
        latch(LA, 16'h0100); latch(LB, 16'h0100); latch(LOP, 12);
        send(COMP, 0);
        if (!MUL_EN) model(W, m_op, m_a, m_b, m_f, m_y, m_f);
        repeat (7) @(posedge i_Clk);
        #1;
        i_Reset = 1'b1; bus.i_Command = LA; bus.i_Data = 16'h1234; bus.i_Valid = 1'b1;
        @(posedge i_Clk); #1;
        i_Reset = 1'b0; bus.i_Valid = 1'b0; bus.i_Command = NOP;
        m_a = 0; m_b = 0; m_y = 0; m_f = 0; m_op = 0;
        check("rst_mul_busy_done", {bus.o_Busy, bus.o_Done}, 0);
        expect_yf("rst_mul", 0, 0);
        @(posedge i_Clk); #1;
        check("rst_mul_no_done", bus.o_Done, 0);
        compute("rst_ab_zero");
        expect_yf("rst_ab_zero_k", 0, 16'h0002);

        // Randomized command streams
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: latch(LA, W'($urandom));
                1: latch(LA, ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF);
                default: ;
            endcase
            if ($urandom_range(0, 1) != 0) latch(LB, W'($urandom));
            if ($urandom_range(0, 3) == 0) latch(LF, W'($urandom));
            // Commands with valid low, and reserved codes, must be inert
            if ($urandom_range(0, 2) == 0) begin
                bus.i_Command = 4'($urandom_range(1, 5)); bus.i_Data = W'($urandom);
                @(posedge i_Clk); #1;
                send(4'($urandom_range(8, 15)), W'($urandom));
            end
            latch(LOP, W'($urandom_range(0, 15)));
            compute("rnd");
        end

        // Wide datapath: 0xFFFFFFFF + 1
        send32(LA, 32'hFFFF_FFFF); send32(LB, 32'h1); send32(LOP, 32'h0);
        send32(COMP, 32'h0);
        check("w32_done", bus32.o_Done, 1);
        y0 = 0; f0 = 0;
        model(32, 0, 64'hFFFF_FFFF, 1, 0, y0, f0);
        bus32.i_Valid = 1'b1; bus32.i_Command = OUTY; #1;
        check("w32_y", bus32.o_Data, 0);
        check("w32_y_model", bus32.o_Data, y0);
        bus32.i_Command = OUTF; #1;
        check("w32_f", bus32.o_Data, 32'h3);
        check("w32_f_model", bus32.o_Data, f0);
        bus32.i_Valid = 1'b0; bus32.i_Command = NOP;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/argon_alu_seq.md
ARGON_ALU_SEQ -- requirements
Module: argon_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath and register width; legal values 8, 16, 32, 64.
REQ-002 SHALL have port i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_Command  input  4  command: 0 NOP, 1 LATCHA, 2 LATCHB, 3 LATCHF, 4 LATCHOP, 5 COMPUTE, 6 OUTPUTY, 7 OUTPUTF; 8-15 treated as NOP.
REQ-005 SHALL have port i_Valid  input  1  qualifies i_Command and i_Data; commands with i_Valid low are NOP.
REQ-006 SHALL have port i_Data  input  WIDTH  write data for LATCH commands.
REQ-007 SHALL have port o_Data  output  WIDTH  read data; zero when o_Valid low.
REQ-008 SHALL have port o_Valid  output  1  combinational; high only for valid OUTPUTY/OUTPUTF while not busy.
REQ-009 SHALL have port o_Busy  output  1  registered; high while a multi-cycle operation runs.
REQ-010 SHALL have port o_Done  output  1  registered one-cycle pulse in the cycle after rY/rF are written by COMPUTE.

Function
REQ-011 SHALL hold registers rA, rB, rY, rF (WIDTH bits) and rOp (4 bits); LATCHA/LATCHB/LATCHF write i_Data, LATCHOP writes i_Data[3:0].
REQ-012 SHALL use flag bits of rF: 0 CARRY, 1 ZERO, 2 NEGATIVE, 3 OVERFLOW, 4 ERROR; COMPUTE clears all other bits.
REQ-013 SHALL implement opcodes: 0 ADD, 1 ADC (A+B+C), 2 SUB (A-B), 3 SBC (A-B-C), 4 AND, 5 OR, 6 XOR, 7 NOT (~A), 8 SHL, 9 SHR, 10 ASR, 11 CMP, 12 MUL; 13-15 illegal.
REQ-014 SHALL compute add/sub in WIDTH+1 bits; CARRY = carry-out for ADD/ADC, borrow (1 when unsigned minuend < subtrahend) for SUB/SBC/CMP.
REQ-015 SHALL set OVERFLOW on signed overflow for ADD/ADC/SUB/SBC/CMP, else 0; ZERO = (result == 0); NEGATIVE = result[WIDTH-1].
REQ-016 SHALL take shift amount from rB[$clog2(WIDTH)-1:0]; CARRY = last bit shifted out, 0 when amount is 0.
REQ-017 SHALL for CMP update rF as SUB but leave rY unchanged.
REQ-018 SHALL for illegal opcodes write rY = 0, rF = ERROR only.
REQ-019 SHALL complete non-MUL COMPUTE in one cycle: rY/rF written on the sampling edge, o_Done high the following cycle.
REQ-020 SHALL run MUL as a shift-add FSM: IDLE -> BUSY on valid COMPUTE, BUSY for exactly WIDTH cycles, -> IDLE writing rY = low WIDTH bits of rA*rB, CARRY = (high WIDTH bits != 0), ZERO/NEGATIVE from rY, OVERFLOW = 0.
REQ-021 SHALL raise o_Busy the cycle after MUL COMPUTE is sampled and drop it the cycle rY/rF are written; o_Done pulses the following cycle.
REQ-022 SHALL ignore every command, including LATCH and COMPUTE, while o_Busy is high; o_Valid stays 0; rA/rB/rOp are unchanged.
REQ-023 SHALL accept a new command in the cycle o_Busy falls.
REQ-024 SHALL for back-to-back single-cycle COMPUTEs update rY/rF every cycle, using rF from the previous COMPUTE as carry-in.

Reset
REQ-025 SHALL, with i_Reset high at a rising edge, clear rA, rB, rY, rF, rOp, FSM to IDLE, o_Busy = 0, o_Done = 0, overriding any concurrent command.
REQ-026 SHALL abort an in-progress MUL on reset with no rY/rF update and no o_Done pulse.

Configuration
REQ-027 SHALL, when macro ARGON_ALU_MUL_EN is defined, include the MUL FSM per REQ-020..REQ-022.
REQ-028 SHALL, when ARGON_ALU_MUL_EN is undefined, treat opcode 12 as illegal (REQ-018, single cycle); o_Busy is tied 0.

Verification
REQ-029 SHALL cover: WIDTH=16, A=0xFFFF, B=0x0001, ADD, COMPUTE -> rY=0x0000, rF=0x0003, o_Done next cycle.
REQ-030 SHALL cover: A=0x7FFF, B=0x0001, ADD then OUTPUTF -> o_Data=0x000C; SUB A=0x0000, B=0x0001 -> rY=0xFFFF, rF=0x0005.
REQ-031 SHALL cover: MUL A=0x0100, B=0x0100 with MUL_EN -> o_Busy 16 cycles, LATCHA during busy ignored, rY=0x0000, rF=0x0003; without MUL_EN -> rF=0x0010.
REQ-032 SHALL cover: i_Reset asserted in 8th MUL cycle -> all registers 0, o_Busy 0 next cycle, no o_Done.
REQ-033 SHALL cover: ASR A=0x8001, B=0x0001 -> rY=0xC000, rF=0x0005; opcode 14 -> rY=0, rF=0x0010; WIDTH=32 ADD 0xFFFFFFFF+1 -> rF=0x0003.
